// File: rtl/vec_sq_accum_if.sv
// Handshake/bus bundle between the core/ALU side and the sum-of-squares accumulator.
// master = core/ALU driver side, slave = accumulator block.
interface vec_sq_accum_if #(
  parameter int ACC_W = 40,
  parameter int LEN_W = 16
);
  logic             Start;
  logic [LEN_W-1:0] VecLen;
  logic             Abort;
  logic             InValid;
  logic [31:0]      InData;
  logic             InReady;
  logic             Vec_en;
  logic             Busy;
  logic             Done;
  logic [ACC_W-1:0] Result;
  logic             Overflow;

  modport master (
    output Start, VecLen, Abort, InValid, InData,
    input  InReady, Vec_en, Busy, Done, Result, Overflow
  );

  modport slave (
    input  Start, VecLen, Abort, InValid, InData,
    output InReady, Vec_en, Busy, Done, Result, Overflow
  );
endinterface

// File: rtl/vec_sq_accum.sv
// Accumulates ALU sum-of-squares outputs over a programmed vector length and
// reports the final sum through a Start/Done handshake.
module vec_sq_accum #(
  parameter int ACC_W = 40,
  parameter int LEN_W = 16
) (
  input  logic           clk,
  input  logic           rst,
  vec_sq_accum_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] result_q, result_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             ovf_run_q, ovf_run_d;
  logic             ovf_q, ovf_d;

  logic [ACC_W:0]   sum_s;
  logic             last_s;

  // The extra top bit is the carry out of the accumulator.
  assign sum_s  = {1'b0, acc_q} + (ACC_W+1)'(bus.InData);
  assign last_s = (cnt_q == (len_q - LEN_W'(1)));

  // All state and datapath registers; rst clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      result_q  <= '0;
      cnt_q     <= '0;
      len_q     <= '0;
      ovf_run_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      result_q  <= result_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      ovf_run_q <= ovf_run_d;
      ovf_q     <= ovf_d;
    end
  end

  // Next-state and datapath update. Overflow of the running job is kept
  // separately so an aborted job leaves the published flag untouched.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    result_d  = result_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    ovf_run_d = ovf_run_q;
    ovf_d     = ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.Start) begin
          if (bus.VecLen != '0) begin
            state_d   = RUN;
            len_d     = bus.VecLen;
            acc_d     = '0;
            cnt_d     = '0;
            ovf_run_d = 1'b0;
          end else begin
            state_d  = DONE;
            result_d = '0;
            ovf_d    = 1'b0;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (bus.Abort) begin
          state_d = IDLE;
        end else if (bus.InValid) begin
          acc_d     = sum_s[ACC_W-1:0];
          cnt_d     = cnt_q + LEN_W'(1);
          ovf_run_d = ovf_run_q | sum_s[ACC_W];
          if (last_s) begin
            state_d  = DONE;
            result_d = sum_s[ACC_W-1:0];
            ovf_d    = ovf_run_q | sum_s[ACC_W];
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Handshake outputs decode straight from the state register.
  assign bus.InReady  = (state_q == RUN);
  assign bus.Vec_en   = (state_q == RUN);
  assign bus.Busy     = (state_q == RUN);
  assign bus.Done     = (state_q == DONE);
  assign bus.Result   = result_q;
  assign bus.Overflow = ovf_q;

endmodule

// File: tb/tb_vec_sq_accum.sv
// Directed-vector bench for vec_sq_accum: stimulus pushes expected {Overflow, Result}
// into a queue, a monitor pops and compares on every Done pulse.
module tb_vec_sq_accum;
  localparam int ACC_W = 33;
  localparam int LEN_W = 16;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [ACC_W:0] exp_q[$];

  vec_sq_accum_if #(.ACC_W(ACC_W), .LEN_W(LEN_W)) bus ();

  vec_sq_accum #(.ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic set_idle();
    bus.Start   = 1'b0;
    bus.VecLen  = '0;
    bus.Abort   = 1'b0;
    bus.InValid = 1'b0;
    bus.InData  = 32'd0;
  endtask

  task automatic start_job(input logic [LEN_W-1:0] len);
    bus.Start  = 1'b1;
    bus.VecLen = len;
    cyc();
    bus.Start  = 1'b0;
    bus.VecLen = 16'hFFFF;
  endtask

  task automatic beat(input logic [31:0] d);
    bus.InValid = 1'b1;
    bus.InData  = d;
    cyc();
    bus.InValid = 1'b0;
    bus.InData  = 32'hDEAD_BEEF;
  endtask

  // Monitor: every Done pulse must match the oldest expected completion.
  always @(negedge clk) begin
    if (!rst && bus.Done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got Result=0x%0h Overflow=%0b expected no Done",
                 bus.Result, bus.Overflow);
      end else begin
        logic [ACC_W:0] e;
        e = exp_q.pop_front();
        chk("done_result", 64'(bus.Result), 64'(e[ACC_W-1:0]));
        chk("done_overflow", 64'(bus.Overflow), 64'(e[ACC_W]));
      end
    end
  end

  initial begin
    int bcnt;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    set_idle();
    repeat (3) cyc();
    rst = 1'b0;
    chk("reset_busy", 64'(bus.Busy), 64'd0);
    chk("reset_inready", 64'(bus.InReady), 64'd0);
    chk("reset_vec_en", 64'(bus.Vec_en), 64'd0);
    chk("reset_done", 64'(bus.Done), 64'd0);
    chk("reset_result", 64'(bus.Result), 64'd0);
    chk("reset_overflow", 64'(bus.Overflow), 64'd0);
    cyc();

    // Basic: 5 + 25 + 13 = 43, Done one cycle after third accept, Busy 3 cycles.
    exp_q.push_back({1'b0, 33'd43});
    start_job(16'd3);
    bcnt = 0;
    if (bus.Busy) bcnt++;
    beat(32'd5);
    if (bus.Busy) bcnt++;
    beat(32'd25);
    if (bus.Busy) bcnt++;
    beat(32'd13);
    if (bus.Busy) bcnt++;
    chk("basic_done_latency", 64'(bus.Done), 64'd1);
    cyc();
    if (bus.Busy) bcnt++;
    chk("basic_done_one_cycle", 64'(bus.Done), 64'd0);
    chk("basic_busy_cycles", 64'(bcnt), 64'd3);

    // Abort after 2 beats: no Done, Result stays 43; beat in the Abort cycle ignored.
    start_job(16'd4);
    beat(32'd1);
    beat(32'd2);
    bus.Abort   = 1'b1;
    bus.InValid = 1'b1;
    bus.InData  = 32'd50;
    cyc();
    set_idle();
    chk("abort_busy", 64'(bus.Busy), 64'd0);
    chk("abort_done", 64'(bus.Done), 64'd0);
    chk("abort_result_hold", 64'(bus.Result), 64'd43);
    repeat (3) cyc();
    exp_q.push_back({1'b0, 33'd9});
    start_job(16'd1);
    beat(32'd9);
    repeat (2) cyc();

    // Stalls: valid pattern 1,0,0,1 carrying 100 and 7, junk on invalid cycles.
    exp_q.push_back({1'b0, 33'd107});
    start_job(16'd2);
    beat(32'd100);
    bus.InData = 32'd55;
    cyc();
    bus.InData = 32'd66;
    cyc();
    chk("stall_still_busy", 64'(bus.Busy), 64'd1);
    beat(32'd7);
    repeat (2) cyc();

    // Zero length: Done right after Start, Vec_en never raised.
    exp_q.push_back({1'b0, 33'd0});
    start_job(16'd0);
    chk("zero_len_done", 64'(bus.Done), 64'd1);
    chk("zero_len_vec_en", 64'(bus.Vec_en), 64'd0);
    cyc();
    chk("zero_len_vec_en_after", 64'(bus.Vec_en), 64'd0);

    // Start during RUN is ignored: exactly 4 beats 1+2+3+4 = 10.
    exp_q.push_back({1'b0, 33'd10});
    start_job(16'd4);
    beat(32'd1);
    bus.Start  = 1'b1;
    bus.VecLen = 16'd2;
    beat(32'd2);
    bus.Start  = 1'b0;
    beat(32'd3);
    chk("ignored_start_busy", 64'(bus.Busy), 64'd1);
    beat(32'd4);
    cyc();
    cyc();
    chk("ignored_start_not_queued", 64'(bus.Busy), 64'd0);

    // Overflow: 3 x 0xFFFFFFFF wraps the 33-bit accumulator.
    exp_q.push_back({1'b1, 33'h0_FFFF_FFFD});
    start_job(16'd3);
    beat(32'hFFFF_FFFF);
    beat(32'hFFFF_FFFF);
    beat(32'hFFFF_FFFF);
    repeat (2) cyc();

    // Reset mid-RUN after 2 of 5 beats clears everything.
    start_job(16'd5);
    beat(32'd11);
    beat(32'd12);
    rst         = 1'b1;
    bus.InValid = 1'b1;
    bus.InData  = 32'd13;
    cyc();
    rst = 1'b0;
    set_idle();
    chk("rst_mid_busy", 64'(bus.Busy), 64'd0);
    chk("rst_mid_inready", 64'(bus.InReady), 64'd0);
    chk("rst_mid_vec_en", 64'(bus.Vec_en), 64'd0);
    chk("rst_mid_result", 64'(bus.Result), 64'd0);
    chk("rst_mid_overflow", 64'(bus.Overflow), 64'd0);
    exp_q.push_back({1'b0, 33'd4});
    start_job(16'd1);
    beat(32'd4);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) cyc();
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
